// File: rtl/compare_sort_ctrl.sv
// Sequential bubble sorter: load up to DEPTH words, sort in place with one shared
// comparator (one compare-and-swap per clock), then stream the words out.
// Build option: define SORT_DESCEND_EN for non-increasing output order.

module comparator_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         desc_i,
  output logic         swap_o
);
  logic gt;
  logic lt;

  always_comb begin
    gt     = (a_i > b_i);
    lt     = (a_i < b_i);
    swap_o = desc_i ? lt : gt;
  end
endmodule

module compare_sort_ctrl #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            in_ready,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [IDXW:0]   count,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  input  logic            out_ready,
  output logic [1:0]      state_dbg
);

  // Handshake rule for both streams: a word moves on a rising clk edge exactly
  // when valid and ready are both high; valid never depends on ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [IDXW:0]   ONE_C   = (IDXW+1)'(1);
  localparam logic [IDXW:0]   TWO_C   = (IDXW+1)'(2);
  localparam logic [IDXW:0]   DEPTH_C = (IDXW+1)'(DEPTH);
  localparam logic [IDXW-1:0] IONE_C  = IDXW'(1);

`ifdef SORT_DESCEND_EN
  localparam logic DESCEND = 1'b1;
`else
  localparam logic DESCEND = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [IDXW:0]   count_q, count_d;
  logic [IDXW-1:0] i_q, i_d;
  logic [IDXW-1:0] p_q, p_d;
  logic            swap_q, swap_d;
  logic [IDXW:0]   rd_q, rd_d;
  logic            done_q, done_d;
  logic [N-1:0]    mem_q [DEPTH];

  logic [IDXW-1:0] i_nxt;
  logic [N-1:0]    cmp_a;
  logic [N-1:0]    cmp_b;
  logic            do_swap;
  logic            load_en;
  logic            swap_en;
  logic            pass_end;
  logic            last_pass;
  logic            out_fire;

  assign i_nxt = i_q + IONE_C;
  assign cmp_a = mem_q[i_q];
  assign cmp_b = mem_q[i_nxt];

  comparator_n #(.N(N)) u_cmp (
    .a_i    (cmp_a),
    .b_i    (cmp_b),
    .desc_i (DESCEND),
    .swap_o (do_swap)
  );

  assign load_en   = in_valid && in_ready;
  assign swap_en   = (state_q == S_SORT) && (count_q >= TWO_C) && do_swap;
  assign pass_end  = ({1'b0, i_q} == (count_q - TWO_C));
  assign last_pass = ({1'b0, p_q} == (count_q - TWO_C));
  assign out_fire  = out_valid && out_ready;

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      i_q     <= '0;
      p_q     <= '0;
      swap_q  <= 1'b0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      p_q     <= p_d;
      swap_q  <= swap_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  // Word storage; contents are not reset because they are only read once loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_en) begin
        mem_q[count_q[IDXW-1:0]] <= in_data;
      end else if (swap_en) begin
        mem_q[i_q]   <= cmp_b;
        mem_q[i_nxt] <= cmp_a;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    i_d     = i_q;
    p_d     = p_q;
    swap_d  = swap_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          count_d = count_q + ONE_C;
        end
        if (start) begin
          state_d = S_SORT;
          i_d     = '0;
          p_d     = '0;
          swap_d  = 1'b0;
        end
      end
      S_SORT: begin
        if (count_q < TWO_C) begin
          state_d = S_DRAIN;
          done_d  = 1'b1;
          rd_d    = '0;
        end else if (pass_end) begin
          // A pass without any swap means the buffer is already ordered.
          if (!(swap_q || do_swap) || last_pass) begin
            state_d = S_DRAIN;
            done_d  = 1'b1;
            rd_d    = '0;
          end else begin
            i_d    = '0;
            p_d    = p_q + IONE_C;
            swap_d = 1'b0;
          end
        end else begin
          i_d    = i_nxt;
          swap_d = swap_q || do_swap;
        end
      end
      S_DRAIN: begin
        if (!out_valid) begin
          state_d = S_IDLE;
          count_d = '0;
          rd_d    = '0;
        end else if (out_fire) begin
          if (rd_q == (count_q - ONE_C)) begin
            state_d = S_IDLE;
            count_d = '0;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + ONE_C;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !start && (count_q < DEPTH_C);
    busy      = (state_q == S_SORT) || (state_q == S_DRAIN);
    done      = done_q;
    count     = count_q;
    out_valid = (state_q == S_DRAIN) && (rd_q < count_q);
    out_data  = out_valid ? mem_q[rd_q[IDXW-1:0]] : '0;
    state_dbg = state_q;
  end

endmodule

// File: doc/compare_sort_ctrl.md
Name: compare_sort_ctrl

Overview:
Sequential sorter that loads up to DEPTH unsigned N-bit words, sorts them in place with bubble-sort passes, and streams them out. Uses a single ComparatorN instance, time-shared: one compare-and-swap per clock. Sits between a producer stream and a consumer stream as a small reorder buffer for lab datapaths.

Parameters:
N, 8, data word width in bits (unsigned compare).
DEPTH, 8, buffer capacity in words; must be >= 2.
IDXW, 3, index width; must satisfy 2**IDXW >= DEPTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  load word present.
in_data  input  N  load word.
in_ready  output  1  load word accepted this cycle when high together with in_valid.
start  input  1  begin sort of currently loaded words (sampled in IDLE only).
busy  output  1  high in SORT and DRAIN.
done  output  1  one-cycle pulse on entry to DRAIN.
count  output  IDXW+1  words currently held.
out_valid  output  1  out_data valid.
out_data  output  N  sorted word at read index.
out_ready  input  1  consumer accepts; transfer on out_valid && out_ready.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, count=0, busy=0, done=0, out_valid=0, out_data=0, all indices/flags 0. Buffer contents are don't-care. Reset mid-SORT or mid-DRAIN aborts immediately; no done pulse.
- States: IDLE, SORT, DRAIN.
- IDLE: in_ready = !start && count<DEPTH. On accepted word: buf[count]<=in_data, count++. Word offered when full or with start high is not written; the producer holds it. start=1 -> SORT next cycle, pass index i=0, pass counter p=0, swap flag cleared.
- SORT: each cycle compares buf[i] (A) against buf[i+1] (B). Ascending: if G then swap both entries at the clock edge and set swap flag. i advances by 1 per cycle. When i==count-2, the pass ends: exit to DRAIN if no swap occurred in this pass (including this cycle) or p==count-2; otherwise i<=0, p++, swap flag cleared.
- count 0 or 1 at start: SORT lasts exactly one cycle, no compares, then DRAIN.
- Latency, count=k>=2: already sorted -> k-1 SORT cycles; worst case (k-1)*(k-1) SORT cycles.
- done=1 exactly in the first DRAIN cycle.
- DRAIN: out_valid=1 while rd_idx<count; out_data=buf[rd_idx]. On transfer rd_idx++. The cycle after the last transfer: state=IDLE, count=0, rd_idx=0, out_valid=0. count=0: DRAIN lasts one cycle with out_valid=0, then IDLE.
- out_data holds its value while out_valid && !out_ready.
- start, in_valid ignored outside IDLE; out_ready ignored outside DRAIN.
- Equal words are never swapped (stable sort).

Optional Feature:
Macro SORT_DESCEND_EN. Defined: swap condition is L (A<B), and the output is in non-increasing order. Not defined: swap condition is G, and the output is in non-decreasing order. All timing and pass-exit rules are identical in both builds.

Test Plan:
- Load 4,1,3,2 (N=8), start, out_ready=1 -> done after 3 passes (9 SORT cycles); out stream 1,2,3,4; then count=0, IDLE.
- Load 1,2,3,4, start -> exactly 3 SORT cycles, then done; out 1,2,3,4.
- Load 8 words (DEPTH=8), offer a 9th word -> in_ready=0, 9th word not stored; reverse order 8..1 sorts to 1..8 in 49 SORT cycles.
- Load 5,5,0xFF,0x00 with out_ready toggling 1,0,1,0 -> out 0x00,5,5,0xFF; out_data stable while stalled.
- start with count=0 -> one SORT cycle, done pulse, one DRAIN cycle with out_valid=0, back to IDLE. Same run with count=1 (value 7) -> out 7.
- Assert rst during the SORT of 4 words -> next cycle IDLE, count=0, busy=0, no done pulse. With SORT_DESCEND_EN defined, 4,1,3,2 -> out 4,3,2,1.
